// File: rtl/hdmi_period_scheduler.sv
// HDMI period scheduler: raster counters, sync generation and the
// control / video-preamble / guard / data-island period sequencing that
// drives the TMDS channel encoders. Every output is a register and
// describes the cx/cy position presented alongside it.
module hdmi_period_scheduler #(
  parameter int H_ACTIVE     = 640,
  parameter int H_TOTAL      = 800,
  parameter int H_SYNC_START = 656,
  parameter int H_SYNC_END   = 752,
  parameter int V_ACTIVE     = 480,
  parameter int V_TOTAL      = 525,
  parameter int V_SYNC_START = 490,
  parameter int V_SYNC_END   = 492,
  parameter int MAX_PACKETS  = 3,
  parameter int DVI_OUTPUT   = 0
) (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic        packet_valid,
  output logic        packet_start,
  output logic [4:0]  island_cycle,
  output logic [2:0]  mode,
  output logic [3:0]  ctl,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] cx,
  output logic [10:0] cy
);

  // The island (preamble, guards, packets, trailing guard) must end before
  // the video preamble of the next line can begin.
  if ((H_ACTIVE + 4 + 12 + 32 * MAX_PACKETS + 12 > H_TOTAL - 10) ||
      (MAX_PACKETS < 1) || (MAX_PACKETS > 18)) begin : g_bad_params
    $error("hdmi_period_scheduler: data island does not fit in horizontal blanking");
  end

  typedef enum logic [2:0] {
    CTRL      = 3'd0,
    VID_PRE   = 3'd1,
    VID_GUARD = 3'd2,
    VIDEO     = 3'd3,
    ISL_PRE   = 3'd4,
    ISL_LEAD  = 3'd5,
    ISL_DATA  = 3'd6,
    ISL_TRAIL = 3'd7
  } state_t;

  localparam logic [11:0] H_ACT_C      = 12'(H_ACTIVE);
  localparam logic [11:0] H_LAST_C     = 12'(H_TOTAL - 1);
  localparam logic [11:0] ISL_SAMPLE_C = 12'(H_ACTIVE + 3);
  localparam logic [11:0] PRE_FIRST_C  = 12'(H_TOTAL - 10);
  localparam logic [11:0] PRE_LAST_C   = 12'(H_TOTAL - 3);
  localparam logic [11:0] GUARD_C      = 12'(H_TOTAL - 2);
  localparam logic [11:0] HS_START_C   = 12'(H_SYNC_START);
  localparam logic [11:0] HS_END_C     = 12'(H_SYNC_END);
  localparam logic [10:0] V_ACT_C      = 11'(V_ACTIVE);
  localparam logic [10:0] V_LAST_C     = 11'(V_TOTAL - 1);
  localparam logic [10:0] VS_START_C   = 11'(V_SYNC_START);
  localparam logic [10:0] VS_END_C     = 11'(V_SYNC_END);
  localparam logic [4:0]  MAX_PKT_C    = 5'(MAX_PACKETS);
  localparam bit          ISLANDS_ON   = (DVI_OUTPUT == 0);

  state_t      state_r;
  state_t      state_s;
  state_t      pos_state_s;
  logic [4:0]  cnt_r;
  logic [4:0]  cnt_s;
  logic [4:0]  pkt_r;
  logic [4:0]  pkt_s;
  logic [11:0] nx_s;
  logic [10:0] ny_s;
  logic [10:0] follow_s;
  logic        pre_line_s;
  logic [2:0]  mode_s;
  logic [3:0]  ctl_s;
  logic [4:0]  ic_s;
  logic        ps_s;
  logic        hsync_s;
  logic        vsync_s;

  // Next raster position and the period that position earns from geometry alone.
  always_comb begin
    nx_s = (cx == H_LAST_C) ? 12'd0 : cx + 12'd1;
    if (cx == H_LAST_C) begin
      ny_s = (cy == V_LAST_C) ? 11'd0 : cy + 11'd1;
    end else begin
      ny_s = cy;
    end
    follow_s   = (ny_s == V_LAST_C) ? 11'd0 : ny_s + 11'd1;
    pre_line_s = (follow_s < V_ACT_C);
    if ((nx_s < H_ACT_C) && (ny_s < V_ACT_C)) begin
      pos_state_s = VIDEO;
    end else if (ISLANDS_ON && pre_line_s && (nx_s >= PRE_FIRST_C) && (nx_s <= PRE_LAST_C)) begin
      pos_state_s = VID_PRE;
    end else if (ISLANDS_ON && pre_line_s && (nx_s >= GUARD_C)) begin
      pos_state_s = VID_GUARD;
    end else begin
      pos_state_s = CTRL;
    end
    hsync_s = (nx_s >= HS_START_C) && (nx_s < HS_END_C);
    vsync_s = (ny_s >= VS_START_C) && (ny_s < VS_END_C);
  end

  // Next-state logic: island phases run on their own counters, all other periods follow position.
  always_comb begin
    state_s = pos_state_s;
    cnt_s   = 5'd0;
    pkt_s   = pkt_r;
    case (state_r)
      ISL_PRE: begin
        if (cnt_r == 5'd7) begin
          state_s = ISL_LEAD;
        end else begin
          state_s = ISL_PRE;
          cnt_s   = cnt_r + 5'd1;
        end
      end
      ISL_LEAD: begin
        if (cnt_r == 5'd1) begin
          state_s = ISL_DATA;
          pkt_s   = 5'd1;
        end else begin
          state_s = ISL_LEAD;
          cnt_s   = cnt_r + 5'd1;
        end
      end
      ISL_DATA: begin
        if (cnt_r != 5'd31) begin
          state_s = ISL_DATA;
          cnt_s   = cnt_r + 5'd1;
        end else if (packet_valid && (pkt_r < MAX_PKT_C)) begin
          state_s = ISL_DATA;
          pkt_s   = pkt_r + 5'd1;
        end else begin
          state_s = ISL_TRAIL;
        end
      end
      ISL_TRAIL: begin
        if (cnt_r == 5'd1) begin
          state_s = pos_state_s;
        end else begin
          state_s = ISL_TRAIL;
          cnt_s   = cnt_r + 5'd1;
        end
      end
      default: begin
        if (ISLANDS_ON && (state_r == CTRL) && (cx == ISL_SAMPLE_C) && packet_valid) begin
          state_s = ISL_PRE;
        end else begin
          state_s = pos_state_s;
        end
      end
    endcase
  end

  // Output encoding for the period about to be presented.
  always_comb begin
    mode_s = 3'd0;
    ctl_s  = 4'd0;
    case (state_s)
      VIDEO:     mode_s = 3'd1;
      VID_PRE:   ctl_s  = 4'b0001;
      VID_GUARD: mode_s = 3'd2;
      ISL_PRE:   ctl_s  = 4'b0101;
      ISL_LEAD:  mode_s = 3'd4;
      ISL_DATA:  mode_s = 3'd3;
      ISL_TRAIL: mode_s = 3'd4;
      default: begin
        mode_s = 3'd0;
        ctl_s  = 4'd0;
      end
    endcase
    ic_s = (state_s == ISL_DATA) ? cnt_s : 5'd0;
    ps_s = (state_s == ISL_DATA) && (cnt_s == 5'd0);
  end

  // State, counters and all outputs advance together so they stay aligned with cx/cy.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      cx           <= H_ACT_C;
      cy           <= V_ACT_C;
      state_r      <= CTRL;
      cnt_r        <= 5'd0;
      pkt_r        <= 5'd0;
      mode         <= 3'd0;
      ctl          <= 4'd0;
      island_cycle <= 5'd0;
      packet_start <= 1'b0;
      hsync        <= 1'b0;
      vsync        <= 1'b0;
    end else begin
      cx           <= nx_s;
      cy           <= ny_s;
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      pkt_r        <= pkt_s;
      mode         <= mode_s;
      ctl          <= ctl_s;
      island_cycle <= ic_s;
      packet_start <= ps_s;
      hsync        <= hsync_s;
      vsync        <= vsync_s;
    end
  end

endmodule

// File: doc/hdmi_period_scheduler.md
HDMI_PERIOD_SCHEDULER -- requirements
Module: hdmi_period_scheduler

Interface
REQ-001 SHALL take parameters: H_ACTIVE=640, H_TOTAL=800, H_SYNC_START=656, H_SYNC_END=752, V_ACTIVE=480, V_TOTAL=525, V_SYNC_START=490, V_SYNC_END=492, MAX_PACKETS=3 (packets per island, 1..18), DVI_OUTPUT=0 (1 = DVI only, no islands or guards).
REQ-002 SHALL fail elaboration unless H_ACTIVE+4 + 12 + 32*MAX_PACKETS + 12 <= H_TOTAL-10.
REQ-003 SHALL have one clock and a synchronous active-high reset; ports:
- clk_pixel  in  1  pixel clock, all logic on rising edge
- reset  in  1  synchronous active-high reset
- packet_valid  in  1  source holds a 32-cycle island packet ready
- packet_start  out  1  first cycle of an island packet; doubles as pop/ack
- island_cycle  out  5  cycle index 0..31 within current packet
- mode  out  3  tmds_channel mode: 0 control, 1 video, 2 video guard, 3 island, 4 island guard
- ctl  out  4  CTL3..CTL0 preamble bits
- hsync, vsync  out  1 each  active-high syncs
- cx  out  12  horizontal position; cy  out  11  vertical position

Function
REQ-004 SHALL advance cx every cycle, wrapping H_TOTAL-1 -> 0; cy SHALL advance when cx wraps, wrapping V_TOTAL-1 -> 0.
REQ-005 SHALL register all outputs; at any cycle every output SHALL describe the cx/cy presented in that same cycle.
REQ-006 hsync SHALL be 1 iff H_SYNC_START <= cx < H_SYNC_END; vsync SHALL be 1 iff V_SYNC_START <= cy < V_SYNC_END.
REQ-007 SHALL implement states CTRL, VID_PRE, VID_GUARD, VIDEO, ISL_PRE, ISL_LEAD, ISL_DATA, ISL_TRAIL.
REQ-008 VIDEO (mode 1, ctl 0) SHALL hold iff cx < H_ACTIVE and cy < V_ACTIVE.
REQ-009 If next line (cy+1 mod V_TOTAL) < V_ACTIVE: cx H_TOTAL-10..H_TOTAL-3 SHALL be VID_PRE (mode 0, ctl 4'b0001); cx H_TOTAL-2..H_TOTAL-1 SHALL be VID_GUARD (mode 2, ctl 0).
REQ-010 Island SHALL start only if packet_valid=1 when cx = H_ACTIVE+3 in CTRL; island occupies cx H_ACTIVE+4.. on any line, active or blanking.
REQ-011 Island sequence: ISL_PRE 8 cycles (mode 0, ctl 4'b0101), ISL_LEAD 2 cycles (mode 4), ISL_DATA 32*n cycles (mode 3), ISL_TRAIL 2 cycles (mode 4), then CTRL.
REQ-012 In ISL_DATA island_cycle SHALL count 0..31 per packet; packet_start SHALL be 1 exactly when island_cycle=0.
REQ-013 At island_cycle=31 a further packet SHALL follow iff packet_valid=1 and packets sent < MAX_PACKETS; otherwise ISL_TRAIL.
REQ-014 packet_valid SHALL be ignored outside the two sampling points (REQ-010, REQ-013); a drop mid-packet SHALL NOT truncate the packet.
REQ-015 All other cycles SHALL be CTRL: mode 0, ctl 0; island_cycle 0 outside ISL_DATA.
REQ-016 DVI_OUTPUT=1: mode SHALL be only 0/1, ctl always 0, no preamble/guard/island, packet_start never 1.
REQ-017 Per-frame schedule SHALL be identical every frame; no state carries across frames except counters.

Reset
REQ-018 reset=1 SHALL, on the next edge, set cx=H_ACTIVE, cy=V_ACTIVE, state CTRL, mode 0, ctl 0, packet_start 0, island_cycle 0, hsync 0, vsync 0.
REQ-019 reset asserted mid-island or mid-preamble SHALL abort immediately; no further packet_start and no trailing guard.
REQ-020 On the first cycle after reset deassertion, counting SHALL resume from the reset position.

Verification
REQ-021 Defaults, packet_valid=0, full frame -> mode=1 exactly 640x480 cycles; per active-target line mode 0/ctl 0001 at cx 790..797, mode 2 at 798..799; mode 3/4 never.
REQ-022 packet_valid=1 only at cx=643 of one line -> ctl 0101 cx 644..651, mode 4 at 652..653, mode 3 at 654..685, packet_start at 654 only, mode 4 at 686..687, mode 0 from 688.
REQ-023 packet_valid held 1 -> exactly 3 packets, packet_start at 654, 686, 718; trailing guard 750..751.
REQ-024 packet_valid 1 at 643 and 685, 0 at 717 -> 2 packets, trailing guard 718..719.
REQ-025 reset pulsed at cx=700 during island -> next cycle cx=640, cy=480, mode 0, ctl 0; no packet_start until a new island.
REQ-026 DVI_OUTPUT=1, packet_valid=1 -> mode only 0/1, ctl 0, packet_start 0 over a full frame; hsync high cx 656..751, vsync high cy 490..491.
